// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: interval timer, postponed-refresh debt and PRE/AR burst sequencer.
// Optional macro SDRAM_AREF_URGENT_EN adds the aref_urgent (debt saturated) output.
module sdram_aref_sched #(
  parameter int T_AREF   = 700,
  parameter int AR_NUM   = 2,
  parameter int TRP      = 2,
  parameter int TRFC     = 7,
  parameter int DEBT_MAX = 4
) (
  input  logic        aref_clk,
  input  logic        aref_rst_n,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_busy,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_bank,
  output logic [12:0] aref_addr,
  output logic        aref_end,
`ifdef SDRAM_AREF_URGENT_EN
  output logic        aref_urgent,
`endif
  output logic        aref_ovf
);

  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_TRP  = 3'd2;
  localparam logic [2:0] ST_AR   = 3'd3;
  localparam logic [2:0] ST_TRFC = 3'd4;
  localparam logic [2:0] ST_END  = 3'd5;

  localparam int CW = $clog2(T_AREF);
  localparam int DW = $clog2(DEBT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(T_AREF - 1);
  localparam logic [DW-1:0] DEBT_FULL = DW'(DEBT_MAX);
  localparam logic [3:0]    TRP_LAST  = 4'(TRP - 1);
  localparam logic [3:0]    TRFC_LAST = 4'(TRFC - 1);
  localparam logic [3:0]    AR_LIMIT  = 4'(AR_NUM);

  logic [2:0]    state;
  logic [CW-1:0] int_cnt;
  logic [DW-1:0] debt;
  logic [3:0]    wait_cnt;
  logic [3:0]    ar_cnt;
  logic          tick;
  logic          retire;

  assign tick   = init_end && (int_cnt == CNT_LAST);
  assign retire = (state == ST_END);

  always_ff @(posedge aref_clk) begin
    if (!aref_rst_n) begin
      int_cnt <= '0;
    end else if (!init_end || int_cnt == CNT_LAST) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + 1'b1;
    end
  end

  // A tick landing on the retiring edge cancels out; a tick into a full debt only flags overflow.
  always_ff @(posedge aref_clk) begin
    if (!aref_rst_n) begin
      debt     <= '0;
      aref_ovf <= 1'b0;
    end else if (tick && !retire) begin
      if (debt == DEBT_FULL) begin
        aref_ovf <= 1'b1;
      end else begin
        debt <= debt + 1'b1;
      end
    end else if (retire && !tick) begin
      debt <= debt - 1'b1;
    end
  end

  always_ff @(posedge aref_clk) begin
    if (!aref_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ar_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_end && debt != '0 && aref_en) begin
            state <= ST_PRE;
          end
        end
        ST_PRE: begin
          state    <= ST_TRP;
          wait_cnt <= '0;
          ar_cnt   <= '0;
        end
        ST_TRP: begin
          if (wait_cnt == TRP_LAST) begin
            state <= ST_AR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_AR: begin
          state    <= ST_TRFC;
          wait_cnt <= '0;
          ar_cnt   <= ar_cnt + 1'b1;
        end
        ST_TRFC: begin
          if (wait_cnt == TRFC_LAST) begin
            state <= (ar_cnt < AR_LIMIT) ? ST_AR : ST_END;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_END: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Command and done pulse trail the state by one clock so they leave the block registered.
  always_ff @(posedge aref_clk) begin
    if (!aref_rst_n) begin
      aref_cmd <= CMD_NOP;
      aref_end <= 1'b0;
    end else begin
      if (state == ST_PRE) begin
        aref_cmd <= CMD_PRECHARGE;
      end else if (state == ST_AR) begin
        aref_cmd <= CMD_AUTO_REF;
      end else begin
        aref_cmd <= CMD_NOP;
      end
      aref_end <= (state == ST_END);
    end
  end

  assign aref_req  = (debt != '0) && (state == ST_IDLE);
  assign aref_busy = (state != ST_IDLE);
  assign aref_bank = 2'b11;
  assign aref_addr = 13'h1fff;

`ifdef SDRAM_AREF_URGENT_EN
  assign aref_urgent = (debt == DEBT_FULL);
`endif

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Self-checking bench for sdram_aref_sched: directed vector table, corner-case sequences and
// randomized traffic checked every cycle against a burst-offset reference model.
module tb_sdram_aref_sched;

  localparam int T_AREF   = 16;
  localparam int AR_NUM   = 2;
  localparam int TRP      = 2;
  localparam int TRFC     = 7;
  localparam int DEBT_MAX = 3;
  localparam int BURST_LEN = 1 + TRP + AR_NUM * (1 + TRFC) + 1;

  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] NOP = 4'b0111;

  logic        aref_clk = 1'b0;
  logic        aref_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        aref_en = 1'b0;
  logic        aref_req;
  logic        aref_busy;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank;
  logic [12:0] aref_addr;
  logic        aref_end;
  logic        aref_ovf;
`ifdef SDRAM_AREF_URGENT_EN
  logic        aref_urgent;
`endif

  sdram_aref_sched #(
    .T_AREF(T_AREF), .AR_NUM(AR_NUM), .TRP(TRP), .TRFC(TRFC), .DEBT_MAX(DEBT_MAX)
  ) dut (
    .aref_clk(aref_clk),
    .aref_rst_n(aref_rst_n),
    .init_end(init_end),
    .aref_en(aref_en),
    .aref_req(aref_req),
    .aref_busy(aref_busy),
    .aref_cmd(aref_cmd),
    .aref_bank(aref_bank),
    .aref_addr(aref_addr),
    .aref_end(aref_end),
`ifdef SDRAM_AREF_URGENT_EN
    .aref_urgent(aref_urgent),
`endif
    .aref_ovf(aref_ovf)
  );

  always #5 aref_clk = ~aref_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a burst is a position 0..BURST_LEN-1 since it started; commands sit at fixed offsets.
  int         m_cnt = 0;
  int         m_debt = 0;
  int         m_pos = -1;
  logic       m_ovf = 1'b0;
  logic       m_end = 1'b0;
  logic [3:0] m_cmd = NOP;

  function automatic logic [3:0] cmdAt(int pos);
    logic [3:0] r;
    r = NOP;
    if (pos == 0) r = PRE;
    for (int j = 0; j < AR_NUM; j++) begin
      if (pos == 1 + TRP + j * (1 + TRFC)) r = AR;
    end
    return r;
  endfunction

  function automatic void modelStep();
    logic t, ret, start;
    if (!aref_rst_n) begin
      m_cnt = 0; m_debt = 0; m_pos = -1; m_ovf = 1'b0; m_end = 1'b0; m_cmd = NOP;
    end else begin
      t     = init_end && (m_cnt == T_AREF - 1);
      ret   = (m_pos == BURST_LEN - 1);
      start = (m_pos < 0) && init_end && aref_en && (m_debt != 0);
      m_cmd = (m_pos >= 0) ? cmdAt(m_pos) : NOP;
      m_end = ret;
      if (ret) m_pos = -1;
      else if (m_pos >= 0) m_pos = m_pos + 1;
      else if (start) m_pos = 0;
      if (t && !ret) begin
        if (m_debt == DEBT_MAX) m_ovf = 1'b1;
        else m_debt = m_debt + 1;
      end else if (ret && !t) begin
        m_debt = m_debt - 1;
      end
      m_cnt = !init_end ? 0 : ((m_cnt == T_AREF - 1) ? 0 : m_cnt + 1);
    end
  endfunction

  function automatic void checkVec(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endfunction

  function automatic void checkOutput();
    checkVec("req",  16'(aref_req),  16'((m_debt != 0) && (m_pos < 0)));
    checkVec("busy", 16'(aref_busy), 16'(m_pos >= 0));
    checkVec("cmd",  16'(aref_cmd),  16'(m_cmd));
    checkVec("end",  16'(aref_end),  16'(m_end));
    checkVec("ovf",  16'(aref_ovf),  16'(m_ovf));
    checkVec("bank", 16'(aref_bank), 16'h0003);
    checkVec("addr", 16'(aref_addr), 16'h1fff);
`ifdef SDRAM_AREF_URGENT_EN
    checkVec("urgent", 16'(aref_urgent), 16'(m_debt == DEBT_MAX));
`endif
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic ie, input logic en);
    aref_rst_n = rst_n;
    init_end   = ie;
    aref_en    = en;
  endtask

  task automatic clockCycle();
    @(posedge aref_clk);
    modelStep();
    #1;
    cyc++;
    checkOutput();
  endtask

  typedef struct {
    logic       rst_n;
    logic       ie;
    logic       en;
    int         n;
    logic       req;
    logic       busy;
    logic       end_p;
    logic       ovf;
    logic [3:0] cmd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ends;
    int pct;

    // First burst after reset release with init_end and aref_en held high.
    vecs[0]  = '{1'b0, 1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, NOP};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b0, NOP};
    vecs[2]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, NOP};
    vecs[3]  = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
    vecs[4]  = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, PRE};
    vecs[5]  = '{1'b1, 1'b1, 1'b1,  2, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
    vecs[6]  = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, AR};
    vecs[7]  = '{1'b1, 1'b1, 1'b1,  7, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
    vecs[8]  = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, AR};
    vecs[9]  = '{1'b1, 1'b1, 1'b1,  7, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
    vecs[10] = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b0, NOP};

    $display("[TB] directed vector table");
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].rst_n, vecs[v].ie, vecs[v].en);
      for (int k = 0; k < vecs[v].n; k++) begin
        clockCycle();
        checkVec("tbl_req",  16'(aref_req),  16'(vecs[v].req));
        checkVec("tbl_busy", 16'(aref_busy), 16'(vecs[v].busy));
        checkVec("tbl_end",  16'(aref_end),  16'(vecs[v].end_p));
        checkVec("tbl_ovf",  16'(aref_ovf),  16'(vecs[v].ovf));
        checkVec("tbl_cmd",  16'(aref_cmd),  16'(vecs[v].cmd));
      end
    end

    $display("[TB] debt accumulation and overflow");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 70; i++) begin
      clockCycle();
      if (i == 48) checkVec("debt3_req", 16'(aref_req), 16'h0001);
      if (i == 63) checkVec("ovf_before_4th", 16'(aref_ovf), 16'h0000);
      if (i == 64) checkVec("ovf_at_4th", 16'(aref_ovf), 16'h0001);
    end

    // init_end is dropped during each burst so no new ticks arrive while the debt drains.
    $display("[TB] draining saturated debt");
    ends = 0;
    for (int i = 0; i < 200 && ends < 3; i++) begin
      applyStimulus(1'b1, (m_pos < 0) ? 1'b1 : 1'b0, 1'b1);
      clockCycle();
      if (aref_end) ends++;
    end
    checkVec("drain_bursts", 16'(ends), 16'd3);
    checkVec("drain_req", 16'(aref_req), 16'h0000);
    checkVec("drain_busy", 16'(aref_busy), 16'h0000);
    checkVec("drain_ovf", 16'(aref_ovf), 16'h0001);

    $display("[TB] tick coincides with burst retirement");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (16) clockCycle();
    checkVec("coin_req_before", 16'(aref_req), 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b1);
    clockCycle();
    checkVec("coin_started", 16'(aref_busy), 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (15) clockCycle();
    clockCycle();
    checkVec("coin_end", 16'(aref_end), 16'h0001);
    checkVec("coin_req", 16'(aref_req), 16'h0001);
    clockCycle();
    checkVec("coin_req_held", 16'(aref_req), 16'h0001);

    $display("[TB] reset mid-TRFC between edges");
    applyStimulus(1'b1, 1'b1, 1'b1);
    clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (6) clockCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    #2;
    checkOutput();
    checkVec("rst_async_busy", 16'(aref_busy), 16'h0001);
    clockCycle();
    checkVec("rst_busy", 16'(aref_busy), 16'h0000);
    checkVec("rst_cmd", 16'(aref_cmd), 16'(NOP));
    checkVec("rst_req", 16'(aref_req), 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (15) clockCycle();
    checkVec("rst_debt_zero", 16'(aref_req), 16'h0000);
    clockCycle();
    checkVec("rst_first_tick", 16'(aref_req), 16'h0001);

`ifdef SDRAM_AREF_URGENT_EN
    $display("[TB] urgent flag");
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) clockCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (47) clockCycle();
    checkVec("urgent_low", 16'(aref_urgent), 16'h0000);
    clockCycle();
    checkVec("urgent_high", 16'(aref_urgent), 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b1);
    clockCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    ends = 0;
    for (int i = 0; i < 40 && ends == 0; i++) begin
      clockCycle();
      if (aref_end) ends = 1;
      else checkVec("urgent_in_burst", 16'(aref_urgent), 16'h0001);
    end
    checkVec("urgent_burst_done", 16'(ends), 16'd1);
    checkVec("urgent_fell", 16'(aref_urgent), 16'h0000);
`endif

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 10; blk++) begin
      case (blk % 3)
        0: pct = 100;
        1: pct = 50;
        default: pct = 10;
      endcase
      for (int i = 0; i < 300; i++) begin
        applyStimulus(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0);
        clockCycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_aref_sched.md
SDRAM_AREF_SCHED -- requirements
Module: sdram_aref_sched

Interface
REQ-001 SHALL expose parameters, one per line:
- T_AREF, 700, refresh interval in clocks (2..65535)
- AR_NUM, 2, AUTO REFRESH commands per burst (1..8)
- TRP, 2, precharge wait in clocks (1..15)
- TRFC, 7, refresh wait in clocks (1..15)
- DEBT_MAX, 4, maximum postponed refreshes held (1..8)
REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports, one per line:
- aref_clk  in  1  clock
- aref_rst_n  in  1  synchronous active-low reset
- init_end  in  1  SDRAM initialisation done
- aref_en  in  1  arbiter grant
- aref_req  out  1  refresh pending, request to arbiter
- aref_busy  out  1  burst in progress
- aref_cmd  out  4  command {cs_n,ras_n,cas_n,we_n}
- aref_bank  out  2  bank address
- aref_addr  out  13  row address
- aref_end  out  1  one-cycle burst-done pulse
- aref_ovf  out  1  sticky debt overflow
- aref_urgent  out  1  debt saturated (only with SDRAM_AREF_URGENT_EN)

Function
REQ-003 Command codes SHALL be PRECHARGE 4'b0010, AUTO_REF 4'b0001, NOP 4'b0111; aref_bank SHALL be 2'b11 and aref_addr 13'h1fff in every cycle.
REQ-004 The interval counter SHALL count 0..T_AREF-1 while init_end=1, wrap to 0, and produce a tick on the edge where it equals T_AREF-1; with init_end=0 it SHALL hold 0.
REQ-005 The debt counter, $clog2(DEBT_MAX+1) bits, SHALL +1 on tick, -1 on the edge leaving END, and stay unchanged when both coincide.
REQ-006 On tick with debt==DEBT_MAX and no simultaneous decrement, debt SHALL stay DEBT_MAX and aref_ovf SHALL set; it clears only on reset.
REQ-007 aref_req SHALL equal (debt!=0 && state==IDLE), combinational from registers.
REQ-008 aref_busy SHALL equal (state!=IDLE), combinational.
REQ-009 FSM states: IDLE, PRE, TRP, AR, TRFC, END. The FSM SHALL move IDLE->PRE when init_end=1, debt!=0 and aref_en=1; aref_en SHALL be ignored when debt==0.
REQ-010 PRE and AR SHALL each last 1 cycle; TRP SHALL last TRP cycles; TRFC SHALL last TRFC cycles, then go to AR if fewer than AR_NUM refreshes have been issued this burst, else to END; END SHALL last 1 cycle and then go to IDLE.
REQ-011 aref_cmd and aref_end SHALL be registered from the current state, lagging it by one cycle. Mapping: PRE->PRECHARGE, AR->AUTO_REF, END->aref_end=1, all other states->NOP/0.
REQ-012 A burst, once started, SHALL complete even if init_end or aref_en falls; one burst retires exactly one debt unit.
REQ-013 Burst length from the PRECHARGE output to the aref_end pulse SHALL be 1+TRP+AR_NUM*(1+TRFC) cycles.

Reset
REQ-014 On an aref_clk edge with aref_rst_n=0, the block SHALL set: state=IDLE, interval counter=0, debt=0, aref_ovf=0, aref_end=0, aref_cmd=NOP, aref_bank=2'b11, aref_addr=13'h1fff. This SHALL also apply mid-burst.
REQ-015 Reset SHALL have no effect between clock edges.

Configuration
REQ-016 With macro SDRAM_AREF_URGENT_EN defined, port aref_urgent SHALL exist and equal (debt==DEBT_MAX). Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-017 The bench SHALL cover these scenarios, with T_AREF=16, AR_NUM=2, TRP=2, TRFC=7, DEBT_MAX=3:
- init_end=1 and aref_en=1 from reset release -> aref_req rises 16 cycles later; outputs PRECHARGE, 2 NOP, AUTO_REF, 7 NOP, AUTO_REF, 7 NOP, then aref_end pulse (19 cycles).
- aref_en=0 for 70 cycles -> debt reaches 3 at the 3rd tick, aref_ovf=1 at the 4th tick, debt stays 3.
- aref_en raised with debt=3 and held -> three back-to-back bursts, debt reaches 0, aref_req falls, aref_ovf stays 1.
- Tick coincides with leaving END at debt=1 -> debt stays 1 and aref_req re-asserts in IDLE.
- aref_rst_n pulled low mid-TRFC, between edges -> outputs unchanged until the next edge, then NOP/2'b11/13'h1fff, aref_busy=0, debt=0.
- With SDRAM_AREF_URGENT_EN defined and debt=3 -> aref_urgent=1; it falls the cycle after a burst retires.
